fx1_simd_imm_pipe: RTL

//  Pipelined, parametrised SIMD immediate-arithmetic unit for the FX1 even pipe.

---
 rtl/spu_fx1_pkg.sv | 20 ++
 rtl/fx1_imm_lane32.sv | 25 ++
 rtl/fx1_simd_imm_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/spu_fx1_pkg.sv
// Shared opcodes and slot widths for the FX1 immediate-arithmetic unit.
package spu_fx1_pkg;
  localparam int HW = 16;
  localparam int WW = 32;

  typedef enum logic [1:0] {
    OP_AHI  = 2'b00,
    OP_AI   = 2'b01,
    OP_SFHI = 2'b10,
    OP_SFI  = 2'b11
  } op_e;

  function automatic logic op_is_word(input op_e op);
    return op[0];
  endfunction

  function automatic logic op_is_sub(input op_e op);
    return op[1];
  endfunction
endpackage

// File: rtl/fx1_imm_lane32.sv
// One 32-bit lane: add immediate or subtract-from immediate on two halfwords or one word.
module fx1_imm_lane32
  import spu_fx1_pkg::*;
(
  input  logic [0:WW-1] ra,
  input  logic [WW-1:0] s,
  input  op_e           op,
  output logic [0:WW-1] res
);
  logic [WW-1:0] a;
  logic [HW:0]   lo;
  logic [HW-1:0] hi;
  logic          cin;
  logic          cmid;

  // s - ra is computed as s + ~ra + 1; halfword mode re-injects cin at bit 16 instead of the carry
  always_comb begin
    cin  = op_is_sub(op);
    a    = cin ? ~ra : ra;
    lo   = {1'b0, a[HW-1:0]} + {1'b0, s[HW-1:0]} + {{HW{1'b0}}, cin};
    cmid = op_is_word(op) ? lo[HW] : cin;
    hi   = a[WW-1:HW] + s[WW-1:HW] + {{(HW-1){1'b0}}, cmid};
    res  = {hi, lo[HW-1:0]};
  end
endmodule

// File: rtl/fx1_simd_imm_pipe.sv
// FX1 SIMD immediate add / subtract-from unit with an elastic STAGES-deep valid/ready pipe.
module fx1_simd_imm_pipe
  import spu_fx1_pkg::*;
#(
  parameter int VEC_W  = 128,
  parameter int IMM_W  = 10,
  parameter int TAG_W  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [0:VEC_W-1] in_ra,
  input  logic [IMM_W-1:0] in_imm,
  input  logic [TAG_W-1:0] in_rt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_rt,
  output logic [0:VEC_W-1] out_result
);
  localparam int NUM_LANES = VEC_W / WW;

  if ((VEC_W % 32) != 0 || STAGES < 1 || STAGES > 4 || IMM_W > 16) begin : g_bad_param
    $error("fx1_simd_imm_pipe: illegal parameter combination");
  end

  op_e              op;
  logic [WW-1:0]    s;
  logic [0:VEC_W-1] lane_res;

  // Halfword ops see the immediate replicated so each lane half adds its own copy
  always_comb begin
    op = op_e'(in_op);
    s  = op_is_word(op) ? WW'($signed(in_imm)) : {2{HW'($signed(in_imm))}};
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fx1_imm_lane32 u_lane (
      .ra  (in_ra[i*WW +: WW]),
      .s   (s),
      .op  (op),
      .res (lane_res[i*WW +: WW])
    );
  end

  logic [STAGES:1]             vld_q, vld_d, free;
  logic [STAGES:1][TAG_W-1:0]  rt_q, rt_d;
  logic [STAGES:1][VEC_W-1:0]  data_q, data_d;

  // free[k]: stage k can take a new beat this cycle (empty, or its contents move on)
  always_comb begin
    free[STAGES] = !vld_q[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 1; k--) free[k] = !vld_q[k] || free[k+1];

    vld_d  = vld_q;
    rt_d   = rt_q;
    data_d = data_q;
    if (free[1]) begin
      vld_d[1] = in_valid;
      if (in_valid) begin
        rt_d[1]   = in_rt;
        data_d[1] = lane_res;
      end
    end
    for (int k = 2; k <= STAGES; k++) begin
      if (free[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          rt_d[k]   = rt_q[k-1];
          data_d[k] = data_q[k-1];
        end
      end
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      rt_q   <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rt_q   <= rt_d;
      data_q <= data_d;
    end
  end

  assign in_ready   = free[1] || flush;
  assign out_valid  = vld_q[STAGES];
  assign out_rt     = rt_q[STAGES];
  assign out_result = data_q[STAGES];
endmodule
